ex_stage: RTL and testbench

- Execute stage that sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Applies operand forwarding, the ALUSrcB immediate select and the ALU operation, then registers the result and the surviving control bits into the EX/MEM pipeline register it owns.
- Supports an optional multi-cycle iterative multiply that stalls the upstream stages through stall_out.

---
 rtl/ex_stage.sv | 200 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage.
//
// Takes operands and controls from the ID/EX register. It forwards operand A and operand B,
// selects the immediate for ALUSrcB, runs the ALU, and writes the result into the EX/MEM
// register that this stage owns.
//
// Optional feature macro: EX_MUL_EN
//   Defined:   ALUOp 111 runs an iterative 16-step shift-add multiply.
//              stall_out holds the upstream stages while it runs.
//   Undefined: stall_out is tied low. ALUOp 111 returns zero in a single cycle.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   regA_in, regB_in         operands from ID/EX
//   imm_in                   extended immediate from ID/EX
//   rd_in                    destination register index
//   RegWrite_in .. ALUSrcB_in control bits from ID/EX
//   ALUOp_in                 ALU operation
//   fwdA_sel, fwdB_sel       forwarding selects
//                            (01 = EX/MEM result, 10 = memwb_data_in, else ID/EX)
//   memwb_data_in            writeback-stage data
//   alu_result_out           registered result
//   store_data_out           registered forwarded operand B (taken before the immediate select)
//   rd_out, *_out controls   registered destination and controls
//   stall_out                combinational; while high, IF/ID and ID/EX hold their contents
module ex_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RD_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] regA_in,
    input  logic [WIDTH-1:0] regB_in,
    input  logic [WIDTH-1:0] imm_in,
    input  logic [RD_W-1:0]  rd_in,
    input  logic             RegWrite_in,
    input  logic             MemRead_in,
    input  logic             MemWrite_in,
    input  logic             MemToReg_in,
    input  logic             ALUSrcB_in,
    input  logic [2:0]       ALUOp_in,
    input  logic [1:0]       fwdA_sel,
    input  logic [1:0]       fwdB_sel,
    input  logic [WIDTH-1:0] memwb_data_in,
    output logic [WIDTH-1:0] alu_result_out,
    output logic [WIDTH-1:0] store_data_out,
    output logic [RD_W-1:0]  rd_out,
    output logic             RegWrite_out,
    output logic             MemRead_out,
    output logic             MemWrite_out,
    output logic             MemToReg_out,
    output logic             stall_out
);

    localparam logic [2:0] OpMul = 3'b111;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_fb;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;

    // Forwarding muxes. Select 11 falls back to the ID/EX value, the same as 00.
    always_comb begin
        unique case (fwdA_sel)
            2'b01:   op_a = alu_result_out;
            2'b10:   op_a = memwb_data_in;
            default: op_a = regA_in;
        endcase
        unique case (fwdB_sel)
            2'b01:   op_fb = alu_result_out;
            2'b10:   op_fb = memwb_data_in;
            default: op_fb = regB_in;
        endcase
        op_b = ALUSrcB_in ? imm_in : op_fb;
    end

    always_comb begin
        alu_res = '0;
        unique case (ALUOp_in)
            3'b000: alu_res = op_a + op_b;
            3'b001: alu_res = op_a - op_b;
            3'b010: alu_res = op_a & op_b;
            3'b011: alu_res = op_a | op_b;
            3'b100: alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            3'b101: alu_res = op_a << op_b[3:0];
            3'b110: alu_res = op_a >> op_b[3:0];
            default: alu_res = '0;  // MUL is handled by the iterative unit when it is enabled
        endcase
    end

`ifdef EX_MUL_EN
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

    mul_state_e       state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] prod_q;
    logic [CntW-1:0]  cnt_q;

    // The DONE state never stalls. A MUL still held in ID/EX therefore cannot restart
    // until the FSM is back in IDLE.
    assign stall_out = (state_q == StBusy) || (state_q == StIdle && ALUOp_in == OpMul);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ALUOp_in == OpMul) begin
                        // Latch the operands so later forwarding changes cannot affect the product.
                        mcand_q  <= op_a;
                        mplier_q <= op_b;
                        prod_q   <= '0;
                        cnt_q    <= '0;
                        state_q  <= StBusy;
                    end
                end
                StBusy: begin
                    if (mplier_q[0]) begin
                        prod_q <= prod_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_q <= StDone;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end
`else
    assign stall_out = 1'b0;
`endif

    // EX/MEM next-state values. A bubble is inserted while the stage is stalled.
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] store_d;
    logic [RD_W-1:0]  rd_d;
    logic             rw_d;
    logic             mr_d;
    logic             mw_d;
    logic             mtr_d;

    always_comb begin
        res_d   = alu_res;
        store_d = op_fb;
        rd_d    = rd_in;
        rw_d    = RegWrite_in;
        mr_d    = MemRead_in;
        mw_d    = MemWrite_in;
        mtr_d   = MemToReg_in;
        if (stall_out) begin
            res_d   = '0;
            store_d = '0;
            rd_d    = '0;
            rw_d    = 1'b0;
            mr_d    = 1'b0;
            mw_d    = 1'b0;
            mtr_d   = 1'b0;
        end
`ifdef EX_MUL_EN
        else if (state_q == StDone) begin
            // The controls are still held in ID/EX; only the data comes from the multiplier.
            res_d = prod_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_out <= '0;
            store_data_out <= '0;
            rd_out         <= '0;
            RegWrite_out   <= 1'b0;
            MemRead_out    <= 1'b0;
            MemWrite_out   <= 1'b0;
            MemToReg_out   <= 1'b0;
        end else begin
            alu_result_out <= res_d;
            store_data_out <= store_d;
            rd_out         <= rd_d;
            RegWrite_out   <= rw_d;
            MemRead_out    <= mr_d;
            MemWrite_out   <= mw_d;
            MemToReg_out   <= mtr_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] regA_in, regB_in, imm_in, memwb_data_in;
    logic [2:0]  rd_in;
    logic        RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrcB_in;
    logic [2:0]  ALUOp_in;
    logic [1:0]  fwdA_sel, fwdB_sel;
    logic [15:0] alu_result_out, store_data_out;
    logic [2:0]  rd_out;
    logic        RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out, stall_out;

`ifdef EX_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    ex_stage #(.WIDTH(16), .RD_W(3)) dut (
        .clk(clk), .rst(rst),
        .regA_in(regA_in), .regB_in(regB_in), .imm_in(imm_in), .rd_in(rd_in),
        .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemToReg_in(MemToReg_in), .ALUSrcB_in(ALUSrcB_in), .ALUOp_in(ALUOp_in),
        .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel), .memwb_data_in(memwb_data_in),
        .alu_result_out(alu_result_out), .store_data_out(store_data_out), .rd_out(rd_out),
        .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .MemToReg_out(MemToReg_out), .stall_out(stall_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Reference model: the expected EX/MEM contents, plus how many cycles of the
    // current MUL have elapsed (0 = no MUL in flight, 17 = result cycle).
    logic [15:0] m_res, m_store, m_ma, m_mb;
    logic [2:0]  m_rd;
    logic        m_rw, m_mr, m_mw, m_mtr;
    int          m_occ = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] fwd(input logic [1:0] sel, input logic [15:0] idex);
        if (sel == 2'b01) return m_res;
        if (sel == 2'b10) return memwb_data_in;
        return idex;
    endfunction

    function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            3'd5: return a << b[3:0];
            3'd6: return a >> b[3:0];
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit model_stall();
        return (m_occ >= 1 && m_occ <= 16) || (MulEn && m_occ == 0 && ALUOp_in == 3'b111);
    endfunction

    // Advance one clock: compute the model's next state from the current inputs, then step.
    task automatic tick();
        logic [15:0] a, fb, b, r, s;
        logic [2:0]  rd;
        logic        rw, mr, mw, mtr;
        int          occ;
        logic [31:0] prod;
        a   = fwd(fwdA_sel, regA_in);
        fb  = fwd(fwdB_sel, regB_in);
        b   = ALUSrcB_in ? imm_in : fb;
        occ = m_occ;
        r = alu(ALUOp_in, a, b); s = fb; rd = rd_in;
        rw = RegWrite_in; mr = MemRead_in; mw = MemWrite_in; mtr = MemToReg_in;
        if (model_stall()) begin
            r = '0; s = '0; rd = '0; rw = 0; mr = 0; mw = 0; mtr = 0;
        end
        if (rst) begin
            r = '0; s = '0; rd = '0; rw = 0; mr = 0; mw = 0; mtr = 0; occ = 0;
        end else if (m_occ == 0 && MulEn && ALUOp_in == 3'b111) begin
            m_ma = a; m_mb = b; occ = 1;
        end else if (m_occ >= 1 && m_occ <= 16) begin
            occ = m_occ + 1;
        end else if (m_occ == 17) begin
            prod = m_ma * m_mb;
            r    = prod[15:0];
            occ  = 0;
        end
        @(posedge clk);
        #1;
        m_res = r; m_store = s; m_rd = rd; m_rw = rw; m_mr = mr; m_mw = mw; m_mtr = mtr;
        m_occ = occ;
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", {31'd0, stall_out}, {31'd0, model_stall()});
            check("alu_result", {16'd0, alu_result_out}, {16'd0, m_res});
            check("store_data", {16'd0, store_data_out}, {16'd0, m_store});
            check("rd", {29'd0, rd_out}, {29'd0, m_rd});
            check("ctrl", {28'd0, RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out},
                  {28'd0, m_rw, m_mr, m_mw, m_mtr});
        end
    end

    task automatic clear_in();
        regA_in = 0; regB_in = 0; imm_in = 0; rd_in = 0; memwb_data_in = 0;
        RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0; MemToReg_in = 0;
        ALUSrcB_in = 0; ALUOp_in = 0; fwdA_sel = 0; fwdB_sel = 0;
    endtask

    initial begin
        int  stall_cnt;
        bit  hold;
        clear_in();
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk_en = 1'b1;
        check("reset_result", {16'd0, alu_result_out}, 32'h0);
        check("reset_regwrite", {31'd0, RegWrite_out}, 32'h0);

        // ADD with immediate, and SUB wrapping modulo 2^16.
        regA_in = 16'h7FFF; imm_in = 16'd1; ALUSrcB_in = 1; ALUOp_in = 3'd0; tick();
        check("add_ovf", {16'd0, alu_result_out}, 32'h8000);
        clear_in(); regA_in = 0; regB_in = 1; ALUOp_in = 3'd1; tick();
        check("sub_wrap", {16'd0, alu_result_out}, 32'hFFFF);
        regA_in = 16'hFFFE; regB_in = 1; ALUOp_in = 3'd4; tick();
        check("slt_signed", {16'd0, alu_result_out}, 32'h0001);
        regA_in = 16'h0001; regB_in = 16'h000F; ALUOp_in = 3'd5; tick();
        check("sll15", {16'd0, alu_result_out}, 32'h8000);
        regA_in = 16'h8000; regB_in = 16'd15; ALUOp_in = 3'd6; tick();
        check("srl15", {16'd0, alu_result_out}, 32'h0001);

        // Forwarding: EX/MEM result = 9, memwb = 7, regA = 5.
        clear_in(); regA_in = 4; imm_in = 5; ALUSrcB_in = 1; tick();
        check("fwd_setup", {16'd0, alu_result_out}, 32'd9);
        regA_in = 5; imm_in = 0; memwb_data_in = 7; fwdA_sel = 2'b01; tick();
        check("fwdA_exmem", {16'd0, alu_result_out}, 32'd9);
        fwdA_sel = 2'b10; tick();
        check("fwdA_memwb", {16'd0, alu_result_out}, 32'd7);
        fwdA_sel = 2'b11; tick();
        check("fwdA_idex", {16'd0, alu_result_out}, 32'd5);
        fwdA_sel = 2'b00; regB_in = 16'h1234; fwdB_sel = 2'b10; MemWrite_in = 1; tick();
        check("store_fwd", {16'd0, store_data_out}, 32'd7);
        check("store_memwrite", {31'd0, MemWrite_out}, 32'd1);

        // Bubble passes through as a no-op.
        clear_in(); tick();
        check("bubble", {12'd0, alu_result_out, RegWrite_out, MemRead_out, MemWrite_out,
              MemToReg_out}, 32'h0);

`ifdef EX_MUL_EN
        // 300 * 200 = 60000 = 0xEA60; followed back-to-back by a second MUL that is reset.
        regA_in = 300; regB_in = 200; ALUOp_in = 3'b111; RegWrite_in = 1; rd_in = 3'd5;
        #1;
        stall_cnt = 0;
        for (int i = 0; i < 40 && stall_out; i++) begin
            stall_cnt++;
            tick();
            check("mul_stall_regwrite", {31'd0, RegWrite_out}, 32'd0);
        end
        check("mul_stall_len", stall_cnt, 32'd17);
        tick();
        check("mul_result", {16'd0, alu_result_out}, 32'hEA60);
        check("mul_regwrite", {31'd0, RegWrite_out}, 32'd1);
        check("mul_b2b_start", {31'd0, stall_out}, 32'd1);
        for (int i = 0; i < 8; i++) tick();
        rst = 1; clear_in(); tick();
        rst = 0;
        check("rst_mid_mul", {12'd0, alu_result_out, RegWrite_out, MemRead_out, MemWrite_out,
              MemToReg_out, stall_out}, 32'h0);
        regA_in = 2; regB_in = 3; RegWrite_in = 1; tick();
        check("add_after_rst", {16'd0, alu_result_out}, 32'd5);
`else
        regA_in = 3; regB_in = 4; ALUOp_in = 3'b111; RegWrite_in = 1; #1;
        check("mul_off_stall", {31'd0, stall_out}, 32'd0);
        tick();
        check("mul_off_result", {16'd0, alu_result_out}, 32'h0);
        check("mul_off_regwrite", {31'd0, RegWrite_out}, 32'd1);
`endif

        // Randomized traffic; ID/EX holds its bundle while the model says the stage stalls.
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                regA_in = 16'($urandom); regB_in = 16'($urandom); imm_in = 16'($urandom);
                rd_in = 3'($urandom); ALUOp_in = 3'($urandom);
                {RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrcB_in} = 5'($urandom);
                fwdA_sel = 2'($urandom); fwdB_sel = 2'($urandom);
            end
            memwb_data_in = 16'($urandom);
            rst = ($urandom_range(0, 63) == 0);
            hold = model_stall();
            tick();
        end
        rst = 0;
        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
